// File: rtl/l2_bus_controller.sv
// Front-side bus controller behind the L2: runs one READ/RFO/WRITEBACK/INVALIDATE
// transaction at a time and returns the fill line plus the MESI state to install.
module l2_bus_controller #(
  parameter int addrBits     = 32,
  parameter int lineSize     = 512,
  parameter int offsetBits   = 6,
  parameter int snoopTimeout = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                reqValid,
  output logic                reqReady,
  input  logic [1:0]          reqOp,
  input  logic [addrBits-1:0] reqAddr,
  input  logic [lineSize-1:0] reqData,
  output logic                respValid,
  output logic [lineSize-1:0] respData,
  output logic [3:0]          respMesi,
  output logic                busCmdValid,
  output logic [1:0]          busCmd,
  output logic [addrBits-1:0] busAddr,
  output logic [lineSize-1:0] busDataOut,
  output logic                busDataOutValid,
  input  logic [lineSize-1:0] busDataIn,
  input  logic                busDataValid,
  input  logic                snoopValid,
  input  logic [1:0]          snoopResult
);
  localparam logic [1:0] OpRead  = 2'b00;
  localparam logic [1:0] OpRfo   = 2'b01;
  localparam logic [1:0] OpWb    = 2'b10;
  localparam logic [1:0] OpInv   = 2'b11;
  localparam logic [1:0] SnNoHit = 2'b00;
  localparam int CntW = (snoopTimeout > 2) ? $clog2(snoopTimeout) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(snoopTimeout - 1);
  localparam logic [addrBits-1:0] OffMask = addrBits'((64'd1 << offsetBits) - 64'd1);

  typedef enum logic [2:0] {IDLE, ADDR, SNOOP, DATA_IN, DATA_OUT, RESP} state_t;

  state_t              state_q;
  logic [CntW-1:0]     cnt_q;
  logic [1:0]          snoop_q;
  logic                reqReady_q, respValid_q, busCmdValid_q, busDataOutValid_q;
  logic [1:0]          busCmd_q;
  logic [addrBits-1:0] busAddr_q;
  logic [lineSize-1:0] respData_q, busDataOut_q;
  logic [3:0]          respMesi_q, mesi_d;
  logic                accept;

  assign accept = reqValid && reqReady_q && (state_q == IDLE);

  always_comb begin
    mesi_d = 4'b0001;
    case (busCmd_q)
      OpRead:       mesi_d = (snoop_q == SnNoHit) ? 4'b0100 : 4'b0010;
      OpRfo, OpInv: mesi_d = 4'b1000;
      default:      mesi_d = 4'b0001;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q           <= IDLE;
      cnt_q             <= '0;
      snoop_q           <= SnNoHit;
      reqReady_q        <= 1'b1;
      respValid_q       <= 1'b0;
      busCmdValid_q     <= 1'b0;
      busDataOutValid_q <= 1'b0;
      busCmd_q          <= 2'b00;
      busAddr_q         <= '0;
      respData_q        <= '0;
      busDataOut_q      <= '0;
      respMesi_q        <= 4'b0001;
    end else begin
      // Bus/response strobes are registered from the state just occupied,
      // so each pulse appears one cycle after its state.
      busCmdValid_q     <= (state_q == ADDR);
      busDataOutValid_q <= (state_q == DATA_OUT);
      respValid_q       <= (state_q == RESP);
      reqReady_q        <= (state_q == IDLE) && !accept;
      if (state_q == RESP) respMesi_q <= mesi_d;
      case (state_q)
        IDLE: if (accept) begin
          state_q   <= ADDR;
          busCmd_q  <= reqOp;
          busAddr_q <= reqAddr & ~OffMask;
          if (reqOp == OpWb) busDataOut_q <= reqData;
        end
        ADDR: begin
          cnt_q   <= '0;
          state_q <= (busCmd_q == OpWb) ? DATA_OUT : SNOOP;
        end
        SNOOP: begin
          if (snoopValid || cnt_q == CntLast) begin
            snoop_q <= snoopValid ? snoopResult : SnNoHit;
            state_q <= (busCmd_q == OpInv) ? RESP : DATA_IN;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        DATA_IN: if (busDataValid) begin
          respData_q <= busDataIn;
          state_q    <= RESP;
        end
        DATA_OUT: state_q <= RESP;
        RESP:     state_q <= IDLE;
        default:  state_q <= IDLE;
      endcase
    end
  end

  assign reqReady        = reqReady_q;
  assign respValid       = respValid_q;
  assign respData        = respData_q;
  assign respMesi        = respMesi_q;
  assign busCmdValid     = busCmdValid_q;
  assign busCmd          = busCmd_q;
  assign busAddr         = busAddr_q;
  assign busDataOut      = busDataOut_q;
  assign busDataOutValid = busDataOutValid_q;
endmodule

// File: tb/tb_l2_bus_controller.sv
// Directed bench for l2_bus_controller: a cycle-schedule model predicts every
// strobe and response, and a negedge process compares the DUT against it.
module tb_l2_bus_controller;
  localparam int AW = 32;
  localparam int LW = 512;
  localparam int TO = 4;
  localparam logic [LW-1:0] JUNK = {64{8'hEE}};

  logic clock = 1'b0;
  logic reset, reqValid, reqReady, respValid, busCmdValid, busDataOutValid;
  logic busDataValid, snoopValid;
  logic [1:0] reqOp, busCmd, snoopResult;
  logic [AW-1:0] reqAddr, busAddr;
  logic [LW-1:0] reqData, respData, busDataOut, busDataIn;
  logic [3:0] respMesi;

  l2_bus_controller #(.addrBits(AW), .lineSize(LW), .offsetBits(6), .snoopTimeout(TO)) dut (
    .clock(clock), .reset(reset), .reqValid(reqValid), .reqReady(reqReady),
    .reqOp(reqOp), .reqAddr(reqAddr), .reqData(reqData),
    .respValid(respValid), .respData(respData), .respMesi(respMesi),
    .busCmdValid(busCmdValid), .busCmd(busCmd), .busAddr(busAddr),
    .busDataOut(busDataOut), .busDataOutValid(busDataOutValid),
    .busDataIn(busDataIn), .busDataValid(busDataValid),
    .snoopValid(snoopValid), .snoopResult(snoopResult));

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Model: cycle numbers of expected events for the current transaction
  int nerr = 0, nchk = 0;
  bit chk_en = 1'b0;
  int exp_T = 0, exp_cmd = -1, exp_dout = -1, exp_resp = -1;
  int ready_cyc = 0, prev_ready = 0, last_resp = -100;
  logic [1:0] exp_op = 2'b00;
  logic [AW-1:0] exp_addr = '0;
  logic [LW-1:0] exp_wb = '0, model_fill = '0;
  logic [3:0] exp_mesi = 4'b0001;

  task automatic check(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clock) if (chk_en) begin
    check("reqReady", reqReady, (cyc >= prev_ready) && !(cyc >= exp_T && cyc < ready_cyc));
    check("busCmdValid", busCmdValid, cyc == exp_cmd);
    if (cyc == exp_cmd) begin
      check("busCmd", busCmd, exp_op);
      check("busAddr", busAddr, exp_addr);
    end
    check("busDataOutValid", busDataOutValid, cyc == exp_dout);
    if (cyc == exp_dout) check("busDataOut", busDataOut, exp_wb);
    check("respValid", respValid, cyc == exp_resp);
    if (cyc == exp_resp) begin
      check("respMesi", respMesi, exp_mesi);
      check("respData", respData, model_fill);
    end
    if (respValid) last_resp = cyc;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // s: SNOOP cycle index carrying snoopValid (>= TO means never); d: extra DATA_IN wait cycles
  task automatic run_txn(input logic [1:0] op, input logic [AW-1:0] addr, input logic [LW-1:0] wdata,
                         input int s, input logic [1:0] sres, input int d,
                         input logic [LW-1:0] fill, input bit noise, input bit keep);
    int c, snoop_end, data_end;
    logic [1:0] eff;
    c = cyc;
    reqValid = 1'b1; reqOp = op; reqAddr = addr; reqData = wdata;
    prev_ready = ready_cyc;
    exp_T     = ((c > ready_cyc) ? c : ready_cyc) + 1;
    exp_cmd   = exp_T + 1;
    exp_op    = op;
    exp_addr  = addr & ~32'h3f;
    exp_wb    = wdata;
    exp_dout  = -1;
    snoop_end = exp_T + 1 + ((s < TO) ? s : TO - 1);
    eff       = (s < TO) ? sres : 2'b00;
    data_end  = snoop_end + 1 + d;
    case (op)
      2'b00: begin exp_resp = data_end + 2; exp_mesi = (eff == 2'b00) ? 4'b0100 : 4'b0010; model_fill = fill; end
      2'b01: begin exp_resp = data_end + 2; exp_mesi = 4'b1000; model_fill = fill; end
      2'b11: begin exp_resp = snoop_end + 2; exp_mesi = 4'b1000; end
      default: begin exp_dout = exp_T + 2; exp_resp = exp_T + 3; exp_mesi = 4'b0001; end
    endcase
    ready_cyc = exp_resp + 1;
    while (cyc <= exp_resp) begin
      tick();
      snoopValid = 1'b0; snoopResult = 2'b10; busDataValid = 1'b0; busDataIn = JUNK;
      if (!keep && cyc >= exp_T) reqValid = 1'b0;
      if (op != 2'b10 && s < TO && cyc == exp_T + 1 + s) begin
        snoopValid = 1'b1; snoopResult = sres;
      end
      if ((op == 2'b00 || op == 2'b01) && cyc == data_end) begin
        busDataValid = 1'b1; busDataIn = fill;
      end
      if (noise && op == 2'b10 && (cyc == exp_T + 1 || cyc == exp_T + 2)) begin
        snoopValid = 1'b1; busDataValid = 1'b1;
      end
      if (noise && op != 2'b10 && cyc == snoop_end) busDataValid = 1'b1;
    end
  endtask

  initial begin
    bit saw;
    int t0;
    reset = 1'b1; reqValid = 1'b0; reqOp = 2'b00; reqAddr = '0; reqData = '0;
    busDataIn = '0; busDataValid = 1'b0; snoopValid = 1'b0; snoopResult = 2'b00;
    repeat (3) tick();
    check("rst_reqReady", reqReady, 1'b1);
    check("rst_respValid", respValid, 1'b0);
    check("rst_busCmdValid", busCmdValid, 1'b0);
    check("rst_busDataOutValid", busDataOutValid, 1'b0);
    check("rst_busCmd", busCmd, 2'b00);
    check("rst_busAddr", busAddr, 32'h0);
    check("rst_respData", respData, '0);
    check("rst_busDataOut", busDataOut, '0);
    check("rst_respMesi", respMesi, 4'b0001);
    reset = 1'b0;
    tick();
    chk_en = 1'b1;

    // READ, clean line: E, fill returned, line-aligned address
    run_txn(2'b00, 32'h0000_1234, '0, 0, 2'b00, 0, {64{8'hA5}}, 1'b0, 1'b0);
    check("read_latency", last_resp - exp_T, 4);
    check("read_respData", respData, {64{8'hA5}});
    check("read_respMesi", respMesi, 4'b0100);
    check("read_busAddr", busAddr, 32'h0000_1200);
    check("read_busCmd", busCmd, 2'b00);
    tick();

    // READ with snoop timeout, data 3 cycles late: NOHIT -> E
    run_txn(2'b00, 32'h0000_2040, '0, TO + 5, 2'b00, 3, {64{8'h3C}}, 1'b0, 1'b0);
    check("timeout_respMesi", respMesi, 4'b0100);
    // READ with HITM: S and owner data
    run_txn(2'b00, 32'h0000_3080, '0, 1, 2'b10, 0, {64{8'h5A}}, 1'b0, 1'b0);
    check("hitm_respMesi", respMesi, 4'b0010);
    check("hitm_respData", respData, {64{8'h5A}});
    // snoop on the last SNOOP cycle still counts; reserved result behaves like HIT
    run_txn(2'b00, 32'h0000_40C0, '0, TO - 1, 2'b10, 1, {64{8'h77}}, 1'b0, 1'b0);
    run_txn(2'b00, 32'h0000_5100, '0, 0, 2'b11, 0, {64{8'h69}}, 1'b0, 1'b0);
    // data arriving alongside the snoop is dropped; real data comes later
    run_txn(2'b00, 32'h0000_6140, '0, 2, 2'b01, 1, {64{8'hC3}}, 1'b1, 1'b0);
    check("simul_respData", respData, {64{8'hC3}});

    // RFO with HIT, then INVALIDATE with HIT: both M
    run_txn(2'b01, 32'h0000_7180, '0, 0, 2'b01, 0, {64{8'h96}}, 1'b0, 1'b0);
    check("rfo_respMesi", respMesi, 4'b1000);
    run_txn(2'b11, 32'h0000_81C0, '0, 0, 2'b01, 0, JUNK, 1'b0, 1'b0);
    check("inv_latency", last_resp - exp_T, 3);
    check("inv_respData_held", respData, {64{8'h96}});
    run_txn(2'b11, 32'h0000_8200, '0, TO + 5, 2'b00, 0, JUNK, 1'b0, 1'b0);

    // WRITEBACK all ones with stray snoop/data pulses
    run_txn(2'b10, 32'h0000_9FFF, {LW{1'b1}}, 0, 2'b00, 0, JUNK, 1'b1, 1'b0);
    check("wb_latency", last_resp - exp_T, 3);
    check("wb_respMesi", respMesi, 4'b0001);
    check("wb_busDataOut", busDataOut, {LW{1'b1}});
    check("wb_busAddr", busAddr, 32'h0000_9FC0);

    // reset held 2 cycles in DATA_IN aborts the READ
    chk_en = 1'b0;
    reqValid = 1'b1; reqOp = 2'b00; reqAddr = 32'h0000_A000; reqData = '0;
    t0 = cyc + 1;
    tick(); reqValid = 1'b0;
    tick(); snoopValid = 1'b1; snoopResult = 2'b00;
    tick(); snoopValid = 1'b0;
    tick(); reset = 1'b1; busDataValid = 1'b1; busDataIn = {64{8'hBD}};
    tick();
    tick(); reset = 1'b0; busDataValid = 1'b0;
    tick();
    check("abort_start", cyc - t0, 6);
    check("abort_reqReady", reqReady, 1'b1);
    check("abort_respValid", respValid, 1'b0);
    check("abort_respMesi", respMesi, 4'b0001);
    check("abort_respData", respData, '0);
    prev_ready = 0; exp_T = 0; ready_cyc = 0;
    exp_cmd = -1; exp_dout = -1; exp_resp = -1; model_fill = '0;
    chk_en = 1'b1;
    saw = 1'b0;
    repeat (6) begin
      tick();
      if (respValid) saw = 1'b1;
    end
    check("abort_noresp", saw, 1'b0);

    // three READs queued behind a held reqValid
    run_txn(2'b00, 32'h0000_B004, '0, 0, 2'b00, 0, {64{8'h11}}, 1'b0, 1'b1);
    run_txn(2'b00, 32'h0000_B048, '0, 1, 2'b01, 2, {64{8'h22}}, 1'b0, 1'b1);
    run_txn(2'b00, 32'h0000_B08C, '0, 0, 2'b00, 0, {64{8'h33}}, 1'b0, 1'b0);
    check("b2b_last_respData", respData, {64{8'h33}});
    repeat (3) tick();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/l2_bus_controller.md
Name: l2_bus_controller

Overview:
- Downstream neighbour of the L2 cache: takes one miss, upgrade or writeback request at a time and runs it as a transaction on the shared front-side bus (FSB).
- Drives the bus command and line address, collects the snoop result from the other caches, and moves line data in or out.
- Returns the fill data and the resulting MESI state for the cache to install.
- Single outstanding transaction; no pipelining.

Parameters:
addrBits, 32, width of physical byte address
lineSize, 512, line width in bits; also shared bus data width
offsetBits, 6, byte-offset bits cleared from the address (log2(lineSize/8))
snoopTimeout, 4, SNOOP cycles to wait for snoopValid before treating the result as NOHIT

Ports:
clock  input  1  sole clock, rising edge
reset  input  1  synchronous, active-high
reqValid  input  1  request present
reqReady  output  1  controller can accept; high only in IDLE
reqOp  input  2  00 READ, 01 RFO, 10 WRITEBACK, 11 INVALIDATE(upgrade)
reqAddr  input  addrBits  byte address of line
reqData  input  lineSize  line to write back (WRITEBACK only)
respValid  output  1  one-cycle completion pulse
respData  output  lineSize  fill line (valid with respValid for READ/RFO)
respMesi  output  4  one-hot new state: bit3 M, bit2 E, bit1 S, bit0 I
busCmdValid  output  1  command/address phase strobe
busCmd  output  2  reqOp of current transaction
busAddr  output  addrBits  line-aligned address
busDataOut  output  lineSize  writeback data
busDataOutValid  output  1  writeback data strobe
busDataIn  input  lineSize  fill data from DRAM or HITM owner
busDataValid  input  1  busDataIn valid
snoopValid  input  1  snoop result valid
snoopResult  input  2  00 NOHIT, 01 HIT, 10 HITM, 11 reserved (treat as HIT)

Behaviour:
- All outputs registered.
- Reset values:
  - state IDLE, reqReady 1.
  - respValid, busCmdValid, busDataOutValid all 0.
  - busCmd 00; busAddr, respData, busDataOut all 0.
  - respMesi 0001 (I).
- Reset in any state aborts the transaction immediately: no respValid is issued, and the bus strobes drop on the next cycle.
- Accept: a request is accepted on the edge where reqValid && reqReady.
  - reqOp, aligned address (low offsetBits forced to 0) and reqData are latched.
  - reqReady falls the next cycle.
- States:
  - IDLE: reqReady=1. Goes to ADDR on accept.
  - ADDR: exactly one cycle with busCmdValid=1, busCmd and busAddr held.
    - Next state is DATA_OUT for WRITEBACK, SNOOP for all other ops.
  - SNOOP: counter starts at 0 and increments each cycle in SNOOP.
    - snoopValid=1 latches snoopResult and leaves SNOOP.
    - If counter reaches snoopTimeout-1 without snoopValid, the result is NOHIT.
    - snoopValid outside SNOOP is ignored.
    - Next state is DATA_IN for READ/RFO, RESP for INVALIDATE.
  - DATA_IN: waits indefinitely for busDataValid.
    - On busDataValid, captures busDataIn into respData and goes to RESP.
    - For HITM, this captured data is the owner's modified line.
  - DATA_OUT: one cycle with busDataOutValid=1 and busDataOut=latched reqData, then RESP.
  - RESP: one cycle with respValid=1, then IDLE. reqReady returns to 1 the cycle after RESP.
- respMesi encoding:
  - READ: NOHIT gives 0100 (E); HIT or HITM gives 0010 (S).
  - RFO: 1000 (M).
  - INVALIDATE: 1000 (M).
  - WRITEBACK: 0001 (I).
- respData:
  - READ/RFO: the captured fill line.
  - INVALIDATE/WRITEBACK: holds its previous value; the cache must ignore it.
- Minimum latencies (accept edge = T): the response pulse is high in the cycle that follows the listed edge.
  - READ/RFO: respValid rises at T+4 (snoop and data each present on their first cycle).
  - INVALIDATE: respValid rises at T+3.
  - WRITEBACK: respValid rises at T+3.
- Simultaneous snoopValid and busDataValid in SNOOP: only the snoop is consumed. Data must be re-presented in DATA_IN.

Test Plan:
- Reset: hold reset 2 cycles mid-DATA_IN, then release -> reqReady=1, respValid=0, respMesi=0001, and no respValid ever pulses for the aborted transaction.
- READ, clean line: reqAddr=0x0000_1234, snoopResult=NOHIT on the first SNOOP cycle, busDataIn=pattern A5.. on the first DATA_IN cycle -> busAddr=0x0000_1200, busCmd=00, respValid at T+4, respData=A5.., respMesi=0100.
- READ, snoop timeout: snoopValid never asserted, data arrives 3 cycles later -> NOHIT assumed after 4 SNOOP cycles, respMesi=0100. Repeat with HITM -> respMesi=0010 and owner data returned.
- RFO with HIT, then INVALIDATE with snoopValid HIT -> both return respMesi=1000. INVALIDATE has no data phase and respValid at T+3.
- WRITEBACK reqData=all 1s -> busCmdValid one cycle, then busDataOutValid one cycle with busDataOut=all 1s, respMesi=0001, respValid at T+3. Snoop and busDataValid pulses during the transaction are ignored.
- Back-to-back: reqValid held high with 3 queued READs -> each is accepted only when reqReady=1, there are no overlapping busCmdValid pulses, and responses come back in order.
